// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pkg
//  Description : Constants, FSM state encoding and kernel-unpack helper
//                shared by the conv_2d pixel pipeline blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    localparam int NB_PIXEL     = 8;
    localparam int KERNEL_SIZE  = 9;
    localparam int KERNEL_DIM   = 3;
    localparam int LOAD_CYCLES  = 4;
    localparam int DRAIN_CYCLES = 3;
    localparam int NB_KERNEL    = KERNEL_SIZE * NB_PIXEL;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } feeder_state_t;

    // Coefficient k (1..9, row-major) sits at bits [k*NB_PIXEL-1 -: NB_PIXEL].
    function automatic logic [NB_PIXEL-1:0] kernel_coeff(
        input logic [NB_KERNEL-1:0] knl,
        input int                   k
    );
        return knl[NB_PIXEL*k-1 -: NB_PIXEL];
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : conv_addr_gen
//  Description : Row/column scan counters for the column feeder. Keeps a
//                running row base (r*W, stepped by +W) and registers the three
//                row-aligned read addresses for the current column.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64,
    parameter int NB_ADDR    = 12
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_init,
    input  logic               i_step,
    input  logic               i_clear,
    output logic [NB_ADDR-1:0] o_addr1,
    output logic [NB_ADDR-1:0] o_addr2,
    output logic [NB_ADDR-1:0] o_addr3,
    output logic               o_last_col,
    output logic               o_last_row,
    output logic               o_col_ge2
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    localparam logic [NB_ADDR-1:0] C_ROW_STEP  = NB_ADDR'(IMG_WIDTH);
    localparam logic [NB_ADDR-1:0] C_ROW_STEP2 = NB_ADDR'(2 * IMG_WIDTH);
    localparam logic [COL_W-1:0]   C_LAST_COL  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0]   C_LAST_ROW  = ROW_W'(IMG_HEIGHT - 3);
    localparam logic [COL_W-1:0]   C_COL_ONE   = COL_W'(1);
    localparam logic [COL_W-1:0]   C_COL_TWO   = COL_W'(2);
    localparam logic [ROW_W-1:0]   C_ROW_ONE   = ROW_W'(1);

    logic [COL_W-1:0]   col_q,   col_d;
    logic [ROW_W-1:0]   row_q,   row_d;
    logic [NB_ADDR-1:0] base_q,  base_d;
    logic [NB_ADDR-1:0] addr1_q, addr1_d;
    logic [NB_ADDR-1:0] addr2_q, addr2_d;
    logic [NB_ADDR-1:0] addr3_q, addr3_d;

    logic w_last_col;

    assign w_last_col = (col_q == C_LAST_COL);

    // Next scan position and the address triple that goes with it.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        base_d  = base_q;
        addr1_d = addr1_q;
        addr2_d = addr2_q;
        addr3_d = addr3_q;
        if (i_clear) begin
            col_d   = '0;
            row_d   = '0;
            base_d  = '0;
            addr1_d = '0;
            addr2_d = '0;
            addr3_d = '0;
        end else if (i_init || i_step) begin
            if (i_init) begin
                col_d  = '0;
                row_d  = '0;
                base_d = '0;
            end else if (w_last_col) begin
                // Wrap to column 0 of the next row; base advances by one row.
                col_d  = '0;
                row_d  = row_q + C_ROW_ONE;
                base_d = base_q + C_ROW_STEP;
            end else begin
                col_d  = col_q + C_COL_ONE;
            end
            addr1_d = base_d + NB_ADDR'(col_d);
            addr2_d = base_d + NB_ADDR'(col_d) + C_ROW_STEP;
            addr3_d = base_d + NB_ADDR'(col_d) + C_ROW_STEP2;
        end
    end

    // Counter and address registers.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            col_q   <= '0;
            row_q   <= '0;
            base_q  <= '0;
            addr1_q <= '0;
            addr2_q <= '0;
            addr3_q <= '0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            base_q  <= base_d;
            addr1_q <= addr1_d;
            addr2_q <= addr2_d;
            addr3_q <= addr3_d;
        end
    end

    assign o_addr1    = addr1_q;
    assign o_addr2    = addr2_q;
    assign o_addr3    = addr3_q;
    assign o_last_col = w_last_col;
    assign o_last_row = (row_q == C_LAST_ROW);
    assign o_col_ge2  = (col_q >= C_COL_TWO);

endmodule
`default_nettype wire

// File: rtl/conv_column_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : conv_column_feeder
//  Description : Source end of the conv_2d pixel interface. Loads the 3x3
//                kernel, then streams 3-row pixel columns from a frame BRAM,
//                one column per cycle, and signals done/busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_column_feeder
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64,
    parameter int NB_ADDR    = 12
) (
    input  logic                             clk,
    input  logic                             i_rst,
    input  logic                             i_start,
    input  logic [KERNEL_SIZE*NB_PIXEL-1:0]  i_kernel,
    output logic [NB_ADDR-1:0]               o_addr1,
    output logic [NB_ADDR-1:0]               o_addr2,
    output logic [NB_ADDR-1:0]               o_addr3,
    output logic                             o_rd_en,
    input  logic [NB_PIXEL-1:0]              i_rdata1,
    input  logic [NB_PIXEL-1:0]              i_rdata2,
    input  logic [NB_PIXEL-1:0]              i_rdata3,
    output logic                             o_load_knl,
    output logic [NB_PIXEL-1:0]              o_data1,
    output logic [NB_PIXEL-1:0]              o_data2,
    output logic [NB_PIXEL-1:0]              o_data3,
    output logic                             o_data_valid,
    output logic                             o_busy,
    output logic                             o_done
);

    localparam logic [1:0] C_LOAD_LAST  = 2'(LOAD_CYCLES - 1);
    localparam logic [1:0] C_DRAIN_DONE = 2'(DRAIN_CYCLES - 2);
    localparam logic [1:0] C_DRAIN_LAST = 2'(DRAIN_CYCLES - 1);
    localparam logic [1:0] C_KNL_DIM    = 2'(KERNEL_DIM);

    // FSM and control registers
    feeder_state_t          state_q,     state_d;
    logic [1:0]             load_cnt_q,  load_cnt_d;
    logic [1:0]             drain_cnt_q, drain_cnt_d;
    logic [NB_KERNEL-1:0]   kernel_q,    kernel_d;
    logic                   busy_q,      busy_d;
    logic                   done_q,      done_d;
    logic                   load_knl_q,  load_knl_d;
    logic                   rd_en_q,     rd_en_d;

    // Read-return delay line and output datapath registers
    logic                   rdv_q,        rdv_d;
    logic                   rdv_ge2_q,    rdv_ge2_d;
    logic                   pres_ge2_q,   pres_ge2_d;
    logic                   data_valid_q, data_valid_d;
    logic [NB_PIXEL-1:0]    data1_q,      data1_d;
    logic [NB_PIXEL-1:0]    data2_q,      data2_d;
    logic [NB_PIXEL-1:0]    data3_q,      data3_d;

    // Control strobes between FSM, address generator and datapath
    logic                   w_addr_init;
    logic                   w_addr_step;
    logic                   w_addr_clear;
    logic                   w_last_col;
    logic                   w_last_row;
    logic                   w_col_ge2;
    logic                   w_coef_sel;
    logic [1:0]             w_coef_col;
    logic [NB_KERNEL-1:0]   w_coef_src;

    conv_addr_gen #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .NB_ADDR    (NB_ADDR)
    ) u_addr_gen (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_init     (w_addr_init),
        .i_step     (w_addr_step),
        .i_clear    (w_addr_clear),
        .o_addr1    (o_addr1),
        .o_addr2    (o_addr2),
        .o_addr3    (o_addr3),
        .o_last_col (w_last_col),
        .o_last_row (w_last_row),
        .o_col_ge2  (w_col_ge2)
    );

    // Pass sequencing: next state, registered control outputs, scan strobes.
    // Outputs are computed for the cycle being entered so they appear registered.
    always_comb begin
        state_d      = state_q;
        load_cnt_d   = load_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        kernel_d     = kernel_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        load_knl_d   = 1'b0;
        rd_en_d      = 1'b0;
        w_addr_init  = 1'b0;
        w_addr_step  = 1'b0;
        w_addr_clear = 1'b0;
        w_coef_sel   = 1'b0;
        w_coef_col   = 2'd0;
        w_coef_src   = kernel_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    // Kernel is not latched yet, so the first load column comes from the port.
                    state_d    = ST_LOAD;
                    kernel_d   = i_kernel;
                    busy_d     = 1'b1;
                    load_cnt_d = 2'd0;
                    load_knl_d = 1'b1;
                    w_coef_sel = 1'b1;
                    w_coef_src = i_kernel;
                end
            end
            ST_LOAD: begin
                if (load_cnt_q == C_LOAD_LAST) begin
                    state_d     = ST_STREAM;
                    rd_en_d     = 1'b1;
                    w_addr_init = 1'b1;
                end else begin
                    // Fourth load cycle carries zeros: conv_2d wraps its load counter there.
                    load_cnt_d = load_cnt_q + 2'd1;
                    load_knl_d = 1'b1;
                    w_coef_col = load_cnt_q + 2'd1;
                    w_coef_sel = (w_coef_col < C_KNL_DIM);
                end
            end
            ST_STREAM: begin
                if (w_last_col && w_last_row) begin
                    state_d      = ST_DRAIN;
                    drain_cnt_d  = 2'd0;
                    w_addr_clear = 1'b1;
                end else begin
                    rd_en_d     = 1'b1;
                    w_addr_step = 1'b1;
                end
            end
            ST_DRAIN: begin
                drain_cnt_d = drain_cnt_q + 2'd1;
                if (drain_cnt_q == C_DRAIN_DONE) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
                if (drain_cnt_q == C_DRAIN_LAST) begin
                    state_d     = ST_IDLE;
                    drain_cnt_d = 2'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and control output registers.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            load_cnt_q  <= 2'd0;
            drain_cnt_q <= 2'd0;
            kernel_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            load_knl_q  <= 1'b0;
            rd_en_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            kernel_q    <= kernel_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            load_knl_q  <= load_knl_d;
            rd_en_q     <= rd_en_d;
        end
    end

    // Column data and valid delay line: issue -> BRAM return -> present -> valid.
    always_comb begin
        rdv_d        = rd_en_q;
        rdv_ge2_d    = rd_en_q & w_col_ge2;
        pres_ge2_d   = rdv_ge2_q;
        data_valid_d = pres_ge2_q;
        data1_d      = '0;
        data2_d      = '0;
        data3_d      = '0;
        if (w_coef_sel) begin
            data1_d = kernel_coeff(w_coef_src, 1 + int'(w_coef_col));
            data2_d = kernel_coeff(w_coef_src, 4 + int'(w_coef_col));
            data3_d = kernel_coeff(w_coef_src, 7 + int'(w_coef_col));
        end else if (rdv_q) begin
            data1_d = i_rdata1;
            data2_d = i_rdata2;
            data3_d = i_rdata3;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            rdv_q        <= 1'b0;
            rdv_ge2_q    <= 1'b0;
            pres_ge2_q   <= 1'b0;
            data_valid_q <= 1'b0;
            data1_q      <= '0;
            data2_q      <= '0;
            data3_q      <= '0;
        end else begin
            rdv_q        <= rdv_d;
            rdv_ge2_q    <= rdv_ge2_d;
            pres_ge2_q   <= pres_ge2_d;
            data_valid_q <= data_valid_d;
            data1_q      <= data1_d;
            data2_q      <= data2_d;
            data3_q      <= data3_d;
        end
    end

    assign o_rd_en      = rd_en_q;
    assign o_load_knl   = load_knl_q;
    assign o_data1      = data1_q;
    assign o_data2      = data2_q;
    assign o_data3      = data3_q;
    assign o_data_valid = data_valid_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;

endmodule
`default_nettype wire
